// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared constants for the forwarding / hazard scoreboard block.
// Stage indices follow youngest-first order: MEM is checked before WB.
package fwd_hazard_scoreboard_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  // Forward select encoding: 0 reads the register file, k+1 forwards from stage k.
  localparam int unsigned FWD_SEL_RF = 0;

  localparam int unsigned STG_MEM = 0;
  localparam int unsigned STG_WB  = 1;

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Pipeline-side bundle for the forwarding / hazard scoreboard.
// The pipeline drives through master; the scoreboard consumes through slave.
interface fwd_hazard_scoreboard_if #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned FWD_DEPTH   = 2,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned SEL_W       = $clog2(FWD_DEPTH + 1),
  parameter int unsigned STALL_CNT_W = 32
) ();

  logic [NUM_SRC*REG_AW-1:0]   rs_ex;
  logic [NUM_SRC*REG_AW-1:0]   rs_id;
  logic [FWD_DEPTH*REG_AW-1:0] stg_rd;
  logic [FWD_DEPTH-1:0]        stg_we;
  logic                        ld_ex_valid;
  logic [REG_AW-1:0]           ld_ex_rd;
  logic                        issue_valid;
  logic [REG_AW-1:0]           issue_rd;
  logic [LAT_W-1:0]            issue_lat;
  logic                        flush;
  logic                        stall_cnt_clr;

  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        stall;
  logic                        issue_ack;
  logic [(2**REG_AW)-1:0]      busy_vec;
  logic [STALL_CNT_W-1:0]      stall_cnt;

  modport master (
    output rs_ex, rs_id, stg_rd, stg_we, ld_ex_valid, ld_ex_rd,
    output issue_valid, issue_rd, issue_lat, flush, stall_cnt_clr,
    input  fwd_sel, stall, issue_ack, busy_vec, stall_cnt
  );

  modport slave (
    input  rs_ex, rs_id, stg_rd, stg_we, ld_ex_valid, ld_ex_rd,
    input  issue_valid, issue_rd, issue_lat, flush, stall_cnt_clr,
    output fwd_sel, stall, issue_ack, busy_vec, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_scoreboard_sb_entry.sv
// One scoreboard slot: a down-counter loaded with the remaining latency of a
// long-latency writer; busy while nonzero.
module fwd_hazard_scoreboard_sb_entry #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  // A new issue wins over the running decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// EX operand forwarding selects plus ID-stage hazard detection: load-use,
// scoreboard RAW/WAW for variable-latency writers, and a stall-cycle counter.
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned FWD_DEPTH   = 2,
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned SEL_W       = $clog2(FWD_DEPTH + 1),
  parameter int unsigned STALL_CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  fwd_hazard_scoreboard_if.slave bus
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  // Forward select per operand; scanning oldest to youngest lets the youngest match win.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] rs;
    logic [SEL_W-1:0]  sel;

    assign rs = bus.rs_ex[i*REG_AW +: REG_AW];

    always_comb begin
      sel = SEL_W'(FWD_SEL_RF);
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (bus.stg_we[k] && (bus.stg_rd[k*REG_AW +: REG_AW] != '0) &&
            (bus.stg_rd[k*REG_AW +: REG_AW] == rs)) begin
          sel = SEL_W'(k + 1);
        end
      end
    end

    assign bus.fwd_sel[i*SEL_W +: SEL_W] = sel;
  end

  logic [NUM_REGS-1:0] busy;
  logic                load_use, raw_hit, waw_hit;
  logic                stall, issue_ack;
  logic [LAT_W-1:0]    lat_eff;

  always_comb begin
    logic [REG_AW-1:0] rs_i;
    load_use = 1'b0;
    raw_hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_i = bus.rs_id[i*REG_AW +: REG_AW];
      if (bus.ld_ex_valid && (bus.ld_ex_rd != '0) && (rs_i == bus.ld_ex_rd)) begin
        load_use = 1'b1;
      end
      if ((rs_i != '0) && busy[rs_i]) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign waw_hit   = bus.issue_valid && busy[bus.issue_rd];
  assign stall     = (load_use || raw_hit || waw_hit) && !bus.flush;
  assign issue_ack = bus.issue_valid && !stall && !bus.flush;
  assign lat_eff   = (bus.issue_lat == '0) ? LAT_W'(1) : bus.issue_lat;

  // Register 0 is hardwired zero and never tracked; issues to it are acked without effect.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    fwd_hazard_scoreboard_sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (issue_ack && (bus.issue_rd == REG_AW'(r))),
      .load_val (lat_eff),
      .busy     (busy[r])
    );
  end

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.issue_ack = issue_ack;
  assign bus.busy_vec  = busy;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
